// File: rtl/terminal_qsys_base_address_bank.sv
// Avalon-MM bank of double-buffered base-address registers: CPU writes land in shadows,
// and a frame_sync rising edge or a forced commit copies them to out_port. Read latency is 1.
module terminal_qsys_base_address_bank #(
   parameter int                NUM_CH    = 4,
   parameter int                DATA_W    = 32,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [4:0]               address,
   input  logic                     chipselect,
   input  logic                     write_n,
   input  logic                     read_n,
   input  logic [DATA_W/8-1:0]      byteenable,
   input  logic [DATA_W-1:0]        writedata,
   output logic [DATA_W-1:0]        readdata,
   input  logic                     frame_sync,
   output logic [NUM_CH*DATA_W-1:0] out_port,
   output logic                     irq
);

   localparam int BE_W = DATA_W / 8;

   logic [DATA_W-1:0] shadow [NUM_CH];
   logic [DATA_W-1:0] active [NUM_CH];
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] commit_set;
   logic [NUM_CH-1:0] shadow_we;
   logic [1:0]        ctrl;
   logic              commit_done;
   logic              done_next;
   logic              sync_d;
   logic              sync_edge;
   logic              wr;
   logic              rd;
   logic              ctrl_wr;
   logic              commit_wr;
   logic              status_wr;
   logic [DATA_W-1:0] rd_val;

   function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_val,
                                                     input logic [DATA_W-1:0] new_val,
                                                     input logic [BE_W-1:0]   be);
      logic [DATA_W-1:0] r;
      r = old_val;
      for (int b = 0; b < BE_W; b++) begin
         if (be[b]) r[8*b +: 8] = new_val[8*b +: 8];
      end
      return r;
   endfunction

   always_comb begin
      wr        = chipselect & ~write_n;
      rd        = chipselect & ~read_n;
      ctrl_wr   = wr && (address == 5'h10);
      commit_wr = wr && (address == 5'h11);
      status_wr = wr && (address == 5'h12);
      // Edge is tracked regardless of SYNC_EN; only the commit is gated.
      sync_edge = frame_sync & ~sync_d & ctrl[0];
      commit_set = (sync_edge ? pending : '0) | (commit_wr ? writedata[NUM_CH-1:0] : '0);
      done_next  = (|commit_set) | (commit_done & ~(status_wr & writedata[DATA_W-1]));
      shadow_we  = '0;
      rd_val     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (address[4:3] == 2'b00 && address[2:0] == 3'(i)) begin
            shadow_we[i] = wr;
            rd_val       = shadow[i];
         end
         if (address[4:3] == 2'b01 && address[2:0] == 3'(i)) rd_val = active[i];
      end
      if (address == 5'h10) rd_val[1:0] = ctrl;
      if (address == 5'h12) begin
         rd_val[NUM_CH-1:0] = pending;
         rd_val[DATA_W-1]   = commit_done;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            shadow[i] <= RESET_VAL;
            active[i] <= RESET_VAL;
         end
         pending     <= '0;
         ctrl        <= '0;
         commit_done <= 1'b0;
         irq         <= 1'b0;
         sync_d      <= 1'b0;
         readdata    <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (commit_set[i]) active[i] <= shadow[i];
            // A same-cycle write keeps the channel pending: its new data was not committed.
            if (shadow_we[i]) begin
               shadow[i]  <= merge_lanes(shadow[i], writedata, byteenable);
               pending[i] <= 1'b1;
            end else if (commit_set[i]) begin
               pending[i] <= 1'b0;
            end
         end
         if (ctrl_wr && byteenable[0]) ctrl <= writedata[1:0];
         commit_done <= done_next;
         irq         <= done_next & ctrl[1];
         sync_d      <= frame_sync;
         if (rd) readdata <= rd_val;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_out
      assign out_port[g*DATA_W +: DATA_W] = active[g];
   end

endmodule

// File: tb/tb_terminal_qsys_base_address_bank.sv
// Directed bench for terminal_qsys_base_address_bank with NUM_CH=4, DATA_W=32, RESET_VAL=0.
module tb_terminal_qsys_base_address_bank;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [4:0]   address = '0;
   logic         chipselect = 1'b0;
   logic         write_n = 1'b1;
   logic         read_n = 1'b1;
   logic [3:0]   byteenable = '0;
   logic [31:0]  writedata = '0;
   logic [31:0]  readdata;
   logic         frame_sync = 1'b0;
   logic [127:0] out_port;
   logic         irq;

   int n_checks = 0;
   int n_fails  = 0;

   terminal_qsys_base_address_bank #(.NUM_CH(4), .DATA_W(32), .RESET_VAL(32'h0)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .read_n(read_n), .byteenable(byteenable), .writedata(writedata),
      .readdata(readdata), .frame_sync(frame_sync), .out_port(out_port), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ch(input int i);
      return out_port[i*32 +: 32];
   endfunction

   task automatic bus_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      address = a; writedata = d; byteenable = be; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a; chipselect = 1'b1; read_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; read_n = 1'b1;
      d = readdata;
   endtask

   initial begin
      logic [31:0] r;
      repeat (2) @(negedge clk);
      chk("reset_out_port_lo", out_port[31:0], 32'h0);
      chk("reset_out_port_hi", out_port[127:96], 32'h0);
      chk("reset_irq", {31'b0, irq}, 32'h0);
      chk("reset_readdata", readdata, 32'h0);
      reset_n = 1'b1;
      bus_rd(5'h12, r);
      chk("reset_status", r, 32'h0);

      // Shadow write waits for a sync edge.
      bus_wr(5'h01, 32'h1000_0000, 4'hF);
      bus_wr(5'h10, 32'h1, 4'hF);
      chk("ch1_before_edge", ch(1), 32'h0);
      bus_rd(5'h12, r);
      chk("status_pending1", r, 32'h2);
      @(negedge clk); frame_sync = 1'b1;
      @(negedge clk);
      chk("ch1_after_edge", ch(1), 32'h1000_0000);
      bus_rd(5'h12, r);
      chk("status_after_edge", r, 32'h8000_0000);
      @(negedge clk); frame_sync = 1'b0;

      // Sync disabled: edges ignored; forced commit of ch0 and ch2.
      bus_wr(5'h10, 32'h0, 4'hF);
      bus_wr(5'h00, 32'h1234_5678, 4'hF);
      bus_wr(5'h02, 32'h2222_0000, 4'hF);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); frame_sync = 1'b1;
         @(negedge clk); frame_sync = 1'b0;
      end
      chk("ch0_sync_disabled", ch(0), 32'h0);
      chk("ch2_sync_disabled", ch(2), 32'h0);
      bus_wr(5'h11, 32'h5, 4'h0);
      chk("ch0_forced", ch(0), 32'h1234_5678);
      chk("ch2_forced", ch(2), 32'h2222_0000);
      bus_rd(5'h12, r);
      chk("status_after_force", r, 32'h8000_0000);

      // Shadow write coinciding with a sync edge commits the old value.
      bus_wr(5'h03, 32'hA, 4'hF);
      bus_wr(5'h10, 32'h1, 4'hF);
      @(negedge clk);
      frame_sync = 1'b1; address = 5'h03; writedata = 32'hB; byteenable = 4'hF;
      chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      chk("ch3_old_shadow", ch(3), 32'hA);
      bus_rd(5'h0B, r);
      chk("active3_read", r, 32'hA);
      bus_rd(5'h03, r);
      chk("shadow3_read", r, 32'hB);
      bus_rd(5'h12, r);
      chk("status_pending3", r, 32'h8000_0008);
      @(negedge clk); frame_sync = 1'b0;

      // Byte lanes, unmapped channels, read-during-write.
      bus_wr(5'h00, 32'hFFFF_FFFF, 4'b0010);
      bus_rd(5'h00, r);
      chk("shadow0_lane1", r, 32'h1234_FF78);
      @(negedge clk);
      chk("readdata_hold", readdata, 32'h1234_FF78);
      bus_wr(5'h05, 32'hDEAD_BEEF, 4'hF);
      bus_rd(5'h05, r);
      chk("shadow5_unmapped", r, 32'h0);
      bus_rd(5'h0D, r);
      chk("active5_unmapped", r, 32'h0);
      @(negedge clk);
      address = 5'h00; writedata = 32'h55; byteenable = 4'hF;
      chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
      chk("rd_wr_same_addr", readdata, 32'h1234_FF78);

      // Interrupt behaviour.
      bus_wr(5'h12, 32'h8000_0000, 4'h0);
      bus_rd(5'h12, r);
      chk("status_after_w1c", r, 32'h9);
      bus_wr(5'h10, 32'h3, 4'h1);
      chk("irq_idle", {31'b0, irq}, 32'h0);
      bus_wr(5'h11, 32'h1, 4'h0);
      chk("irq_on_commit", {31'b0, irq}, 32'h1);
      chk("ch0_rdwr_commit", ch(0), 32'h55);
      @(negedge clk);
      frame_sync = 1'b1; address = 5'h12; writedata = 32'h8000_0000; byteenable = 4'hF;
      chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; frame_sync = 1'b0;
      chk("irq_set_wins", {31'b0, irq}, 32'h1);
      chk("ch3_edge_commit", ch(3), 32'hB);
      bus_rd(5'h12, r);
      chk("status_set_wins", r, 32'h8000_0000);
      bus_wr(5'h12, 32'h8000_0000, 4'h0);
      chk("irq_cleared", {31'b0, irq}, 32'h0);

      // Asynchronous reset mid-operation.
      #2 reset_n = 1'b0;
      #1;
      chk("midreset_ch0", ch(0), 32'h0);
      chk("midreset_ch3", ch(3), 32'h0);
      @(negedge clk); reset_n = 1'b1;
      bus_rd(5'h03, r);
      chk("midreset_shadow3", r, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
